// File: rtl/washer_pkg.sv
// washer_pkg: panel FSM states, load codes and load-code check shared with washerTop
package washer_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_ACK = 2'd2, RUN = 2'd3} state_t;
   localparam logic [1:0] LOAD_SMALL   = 2'b00;
   localparam logic [1:0] LOAD_MED     = 2'b01;
   localparam logic [1:0] LOAD_LARGE   = 2'b10;
   localparam logic [1:0] LOAD_INVALID = 2'b11;
   function automatic logic load_valid(input logic [1:0] l);
      return l != LOAD_INVALID;
   endfunction
endpackage

// File: rtl/panel_debounce.sv
// panel_debounce: synchroniser chain plus stable-count debouncer for one input vector
module panel_debounce #(
   parameter int WIDTH           = 1,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] db,
   output logic             settled
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
   logic [WIDTH-1:0] sync [SYNC_STAGES];
   logic [CW-1:0] cnt, cnt_n;
   logic chg;
   assign chg = sync[SYNC_STAGES-2] != sync[SYNC_STAGES-1];
   assign cnt_n = chg ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
   assign settled = (cnt == CMAX) && (db == sync[SYNC_STAGES-1]);
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
         cnt <= '0;
         db  <= '0;
      end else begin
         sync[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         cnt <= cnt_n;
         if (cnt_n == CMAX) db <= sync[SYNC_STAGES-1];
      end
   end
endmodule

// File: rtl/washer_panel.sv
// washer_panel: front-panel conditioner issuing qualified Start pulses and latched load codes to washerTop
module washer_panel import washer_pkg::*; #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ACK_TIMEOUT     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startBtn,
   input  logic       doorSw,
   input  logic [1:0] loadSel,
   input  logic       Busy,
   output logic       Start,
   output logic       Door,
   output logic [1:0] load,
   output logic       Reject
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX  = TW'(ACK_TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);
   logic db_start, db_start_q, start_settled, door_settled, load_settled, unused_settled;
   logic armed, req, ok, rej_n, load_en;
   logic [1:0] db_load;
   logic [TW-1:0] tcnt;
   state_t state, state_n;
   panel_debounce #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk(clk), .reset(reset), .raw(startBtn), .db(db_start), .settled(start_settled));
   panel_debounce #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_door (
      .clk(clk), .reset(reset), .raw(doorSw), .db(Door), .settled(door_settled));
   panel_debounce #(.WIDTH(2), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
      .clk(clk), .reset(reset), .raw(loadSel), .db(db_load), .settled(load_settled));
   assign unused_settled = door_settled & load_settled;
   assign req   = armed & db_start & ~db_start_q;
   assign ok    = ~Door & ~Busy & load_valid(db_load);
   assign Start = state == LAUNCH;
   always_comb begin
      state_n = state;
      rej_n   = 1'b0;
      load_en = 1'b0;
      case (state)
         IDLE: begin
            state_n = (req & ok) ? LAUNCH : IDLE;
            rej_n   = req & ~ok;
            load_en = req & ok;
         end
         LAUNCH: begin
            state_n = WAIT_ACK;
            rej_n   = req;
         end
         WAIT_ACK: begin
            state_n = Busy ? RUN : (tcnt == TLAST ? IDLE : WAIT_ACK);
            rej_n   = req | (~Busy & (tcnt == TLAST));
         end
         RUN: begin
            state_n = Busy ? RUN : IDLE;
            rej_n   = req;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         db_start_q <= 1'b0;
         armed      <= 1'b0;
         tcnt       <= '0;
         load       <= LOAD_SMALL;
         Reject     <= 1'b0;
      end else begin
         state      <= state_n;
         db_start_q <= db_start;
         armed      <= armed | (~db_start & start_settled);
         tcnt       <= (state == LAUNCH) ? '0 : (tcnt == TMAX ? tcnt : tcnt + 1'b1);
         load       <= load_en ? db_load : load;
         Reject     <= rej_n;
      end
   end
endmodule

// File: tb/tb_washer_panel.sv
// tb_washer_panel: directed stimulus against a window-based behavioural model of the panel
module tb_washer_panel;
   localparam int S = 2, D = 4, A = 4;
   localparam int M_IDLE = 0, M_LAUNCH = 1, M_WAIT = 2, M_RUN = 3;
   logic clk = 1'b0, reset = 1'b1, startBtn = 1'b0, doorSw = 1'b0, Busy = 1'b0;
   logic [1:0] loadSel = 2'b01;
   logic Start, Door, Reject;
   logic [1:0] load;
   int checks = 0, failures = 0, cyc = 0, st_cnt = 0, rej_cnt = 0;
   int chain [3][S];
   int win [3][D+1];
   int seen [3];
   int dbv [3];
   int rawv [3];
   int armed_m, dbs_prev, mode, waited, m_load, m_rej, req, okv, arm_now, newsyn, same;

   washer_panel dut (.clk(clk), .reset(reset), .startBtn(startBtn), .doorSw(doorSw), .loadSel(loadSel),
                     .Busy(Busy), .Start(Start), .Door(Door), .load(load), .Reject(Reject));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a debounced value adopts the synced value once D+1 consecutive synced samples agree.
   always @(posedge clk) begin
      cyc++;
      rawv[0] = int'(startBtn);
      rawv[1] = int'(doorSw);
      rawv[2] = int'(loadSel);
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < S; j++) chain[i][j] = 0;
            for (int j = 0; j <= D; j++) win[i][j] = 0;
            seen[i] = 1;
            dbv[i] = 0;
         end
         armed_m = 0; dbs_prev = 0; mode = M_IDLE; waited = 0; m_load = 0; m_rej = 0;
      end else begin
         same = 1;
         for (int j = 0; j <= D; j++) if (win[0][j] != 0) same = 0;
         arm_now = (dbv[0] == 0 && seen[0] >= D + 1 && same == 1) ? 1 : 0;
         req = (armed_m == 1 && dbv[0] == 1 && dbs_prev == 0) ? 1 : 0;
         okv = (dbv[1] == 0 && !Busy && dbv[2] != 3) ? 1 : 0;
         m_rej = 0;
         if (mode == M_IDLE) begin
            if (req == 1) begin
               if (okv == 1) begin mode = M_LAUNCH; m_load = dbv[2]; end
               else m_rej = 1;
            end
         end else if (mode == M_LAUNCH) begin
            mode = M_WAIT; waited = 0; m_rej = req;
         end else if (mode == M_WAIT) begin
            m_rej = req;
            if (Busy) mode = M_RUN;
            else begin
               waited++;
               if (waited == A) begin mode = M_IDLE; m_rej = 1; end
            end
         end else begin
            m_rej = req;
            if (!Busy) mode = M_IDLE;
         end
         if (arm_now == 1) armed_m = 1;
         dbs_prev = dbv[0];
         for (int i = 0; i < 3; i++) begin
            newsyn = chain[i][S-2];
            for (int j = S - 1; j > 0; j--) chain[i][j] = chain[i][j-1];
            chain[i][0] = rawv[i];
            for (int j = 0; j < D; j++) win[i][j] = win[i][j+1];
            win[i][D] = newsyn;
            if (seen[i] < D + 1) seen[i]++;
            same = 1;
            for (int j = 0; j <= D; j++) if (win[i][j] != newsyn) same = 0;
            if (seen[i] >= D + 1 && same == 1) dbv[i] = newsyn;
         end
      end
   end

   always @(negedge clk) begin
      chk("start", int'(Start), (mode == M_LAUNCH) ? 1 : 0);
      chk("reject", int'(Reject), m_rej);
      chk("door", int'(Door), dbv[1]);
      chk("load", int'(load), m_load);
      if (Start) st_cnt++;
      if (Reject) rej_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sig(input int which, output int at);
      at = -1000;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((which == 0 ? Start : Reject) == 1'b1) begin at = cyc; break; end
      end
   endtask

   initial begin
      int rise, t, r, s0, r0;
      tick(10);
      reset = 1'b0;
      tick(10);
      // 1: clean press, Busy follows two cycles after Start
      s0 = st_cnt; r0 = rej_cnt;
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      chk("t1_latency", t - rise, 7);
      tick(1); startBtn = 1'b0;
      tick(1); Busy = 1'b1;
      tick(4); Busy = 1'b0;
      tick(10);
      chk("t1_starts", st_cnt - s0, 1);
      chk("t1_rejects", rej_cnt - r0, 0);
      chk("t1_load", int'(load), 1);
      // 2: bouncy press
      s0 = st_cnt;
      for (int i = 0; i < 12; i++) begin startBtn = (i % 4) < 2; tick(1); end
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      chk("t2_latency", t - rise, 7);
      tick(1); startBtn = 1'b0;
      tick(1); Busy = 1'b1;
      tick(4); Busy = 1'b0;
      tick(10);
      chk("t2_starts", st_cnt - s0, 1);
      // 3: door open, then invalid load code
      doorSw = 1'b1; tick(10);
      chk("t3_door", int'(Door), 1);
      s0 = st_cnt;
      rise = cyc; startBtn = 1'b1;
      wait_sig(1, r);
      chk("t3_rej_at", r - rise, 7);
      tick(2); startBtn = 1'b0; tick(10);
      chk("t3_starts", st_cnt - s0, 0);
      chk("t3_load", int'(load), 1);
      doorSw = 1'b0; loadSel = 2'b11; tick(10);
      rise = cyc; startBtn = 1'b1;
      wait_sig(1, r);
      chk("t3b_rej_at", r - rise, 7);
      tick(2); startBtn = 1'b0; tick(10);
      chk("t3b_starts", st_cnt - s0, 0);
      chk("t3b_load", int'(load), 1);
      // 4: launch with no acknowledge
      loadSel = 2'b00; tick(10);
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      startBtn = 1'b0;
      wait_sig(1, r);
      chk("t4_timeout", r - t, 5);
      tick(10);
      chk("t4_load", int'(load), 0);
      s0 = st_cnt;
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      chk("t4_relaunch", t - rise, 7);
      tick(1); startBtn = 1'b0;
      tick(1); Busy = 1'b1;
      // 5: press while running with a new load code
      loadSel = 2'b10; tick(10);
      rise = cyc; startBtn = 1'b1;
      wait_sig(1, r);
      chk("t5_rej_at", r - rise, 7);
      tick(2); startBtn = 1'b0; tick(10);
      chk("t5_load_held", int'(load), 0);
      chk("t5_starts", st_cnt - s0, 1);
      Busy = 1'b0; tick(3);
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      chk("t5_latency", t - rise, 7);
      tick(1); startBtn = 1'b0;
      tick(1);
      chk("t5_load_new", int'(load), 2);
      Busy = 1'b1;
      tick(4); Busy = 1'b0; tick(10);
      // 6: reset mid-run with button held
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      tick(2); Busy = 1'b1;
      tick(4);
      reset = 1'b1; Busy = 1'b0;
      tick(1);
      reset = 1'b0;
      chk("t6_start", int'(Start), 0);
      chk("t6_reject", int'(Reject), 0);
      chk("t6_load", int'(load), 0);
      chk("t6_door", int'(Door), 0);
      s0 = st_cnt;
      tick(20);
      chk("t6_held", st_cnt - s0, 0);
      startBtn = 1'b0; tick(12);
      rise = cyc; startBtn = 1'b1;
      wait_sig(0, t);
      chk("t6_repress", t - rise, 7);
      tick(1); startBtn = 1'b0;
      tick(1); Busy = 1'b1;
      tick(4); Busy = 1'b0; tick(10);
      chk("t6_starts", st_cnt - s0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
